// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller.
package hazard_ctrl_pkg;

  // Controller state: normal flow, waiting on mul/div result, frozen on data memory.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // x0 is hardwired to zero, so a write to it never creates a dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : hazard_ctrl_pkg

// File: rtl/sat_counter.sv
// Saturating event counter; reusable for the core performance counters.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count qualifying cycles and stick at all-ones instead of wrapping.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule : sat_counter

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the IF/EX/MEM core: load-use stalls,
// taken-branch flush, fixed-latency mul/div sequencing and data-memory freeze.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_if,
  input  logic [4:0]       rs2_if,
  input  logic             uses_rs1_if,
  input  logic             uses_rs2_if,
  input  logic             is_md_if,
  input  logic             ex_is_load,
  input  logic             ex_wren,
  input  logic [4:0]       rd_ex,
  input  logic             branch_taken_ex,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_if,
  output logic             bubble_ex,
  output logic             flush_if,
  output logic             hold_all,
  output logic             md_start,
  output logic             md_valid,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  state_t     state, state_nxt;
  logic [3:0] md_cnt, md_cnt_nxt;
  logic       mem_stall;
  logic       lu_hazard;

  assign mem_stall = mem_req & ~mem_ready;
  assign lu_hazard = ex_is_load & ex_wren & (rd_ex != REG_ZERO) &
                     ((uses_rs1_if & (rd_ex == rs1_if)) |
                      (uses_rs2_if & (rd_ex == rs2_if)));

  // Decode pipeline controls and next state from the current state and hazards.
  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    stall_if   = 1'b0;
    bubble_ex  = 1'b0;
    flush_if   = 1'b0;
    hold_all   = 1'b0;
    md_start   = 1'b0;
    md_valid   = 1'b0;
    md_busy    = 1'b0;

    unique case (state)
      MD_WAIT: begin
        // EX only holds bubbles here, so branch_taken_ex cannot be meaningful.
        md_busy = 1'b1;
        if (md_cnt != 4'd0) begin
          // The unit keeps computing through a memory freeze.
          md_cnt_nxt = md_cnt - 4'd1;
          stall_if   = 1'b1;
          bubble_ex  = 1'b1;
          hold_all   = mem_stall;
        end else if (mem_stall) begin
          hold_all = 1'b1;
          stall_if = 1'b1;
        end else begin
          md_valid  = 1'b1;
          state_nxt = RUN;
        end
      end

      default: begin
        // RUN and MEM_WAIT share one priority chain: leaving MEM_WAIT costs no cycle.
        if (mem_stall) begin
          hold_all  = 1'b1;
          stall_if  = 1'b1;
          state_nxt = MEM_WAIT;
        end else if (branch_taken_ex) begin
          // IF instruction is squashed, so its hazards are irrelevant.
          flush_if  = 1'b1;
          state_nxt = RUN;
        end else if (lu_hazard) begin
          // One bubble suffices: next cycle the load is in MEM and forwards.
          stall_if  = 1'b1;
          bubble_ex = 1'b1;
          state_nxt = RUN;
        end else if (is_md_if) begin
          md_start   = 1'b1;
          stall_if   = 1'b1;
          bubble_ex  = 1'b1;
          md_cnt_nxt = 4'(MD_LATENCY - 1);
          state_nxt  = MD_WAIT;
        end else begin
          state_nxt = RUN;
        end
      end
    endcase
  end

  // Register controller state and the mul/div countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      md_cnt <= 4'd0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_if),
    .count(stall_cycles)
  );

endmodule : hazard_ctrl
